cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares one next-level cache port between two lower-level requesters: requester 0 is the instruction L1, requester 1 is the data L1.
- Arbitrates round-robin, latches the winner's address, operation and write data, and holds the transaction on the next-level port until the next level returns valid.
- Routes the response back to the winner only.
- Forwards next-level evict notifications to both requesters and adds a response timeout with a sticky error flag.

Parameters:
- ADDRBITS, 32, address width.
- DATABITS, 512, line data width (16 words x 32 bits).
- TIMEOUT, 64, maximum cycles in BUSY waiting for nl_valid; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_request  in  2  per-requester request, held high until req_valid for that requester.
- req_op  in  2x2  per-requester operation: NOP=0, READ=1, WRITE=2, RFO=3.
- req_addr  in  2xADDRBITS  per-requester address.
- req_wdata  in  2xDATABITS  per-requester write data.
- req_valid  out  2  one-cycle response pulse to the granted requester.
- req_err  out  1  qualifies req_valid: the response is a timeout abort.
- req_rdata  out  DATABITS  response data, shared by both requesters, meaningful only with req_valid.
- req_evict  out  2  next-level evict, replicated to both requesters.
- nl_request  out  1  request to the next level.
- nl_op  out  2  latched operation.
- nl_addr  out  ADDRBITS  latched address.
- nl_wdata  out  DATABITS  latched write data.
- nl_valid  in  1  next-level completion.
- nl_rdata  in  DATABITS  next-level read data.
- nl_evict  in  1  next-level evict notification.
- grant_id  out  1  id of the requester currently or last granted.
- err_timeout  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, immediate effect):
  - state=IDLE; priority pointer=0; grant_id=0; timeout counter=0.
  - Latches cleared to 0; req_valid=0, req_err=0, req_rdata=0.
  - nl_request=0, nl_op=NOP, nl_addr=0, nl_wdata=0; err_timeout=0.
- req_evict = {nl_evict, nl_evict}. This path is combinational and is active in every state.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If nl_evict=1, no grant is issued and the FSM stays in IDLE.
  - Otherwise, if any req_request bit is high, the winner is the requester selected by the pointer if it is requesting, else the other requester.
  - At the winning edge: latch that requester's op, addr and wdata; grant_id=winner; counter=0; go to BUSY.
  - A request with op=NOP is still granted and forwarded unchanged.
- BUSY:
  - nl_request=1; nl_op, nl_addr and nl_wdata come from the latches.
  - Requester-side input changes are ignored until the transaction completes.
  - nl_evict is ignored and does not abort the transaction.
  - nl_valid=1: capture nl_rdata into req_rdata; go to DONE.
  - Otherwise counter increments; when counter reaches TIMEOUT-1 with no nl_valid: set err_timeout; set a pending-error bit; go to DONE. req_rdata holds its previous value.
  - If nl_valid arrives in the same cycle the limit is reached, the transaction completes normally and no error is raised.
- DONE (exactly one cycle):
  - nl_request=0; req_valid[grant_id]=1; req_err=pending-error bit.
  - Pointer becomes ~grant_id; pending-error bit clears; go to IDLE.
- Requester obligations:
  - Deassert req_request at the edge ending the DONE cycle.
  - The arbiter samples requests only in IDLE. A request still high there is treated as a new transaction.
- Latency: grant occurs at the first IDLE edge. nl_request rises the cycle after. req_valid is asserted 1 cycle after nl_valid. Minimum request-to-valid is 3 cycles when nl_valid arrives the first BUSY cycle.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- Simultaneous requests: both requesters are served back-to-back, alternating, so neither starves.

Test Plan:
1. After reset, req0 READ addr 0x0000_1000; nl_valid 3 cycles after nl_request rises, nl_rdata={16{32'hDEADBEEF}} -> nl_op=1, nl_addr=0x0000_1000; req_valid=2'b01 for one cycle with req_rdata equal to that pattern; req_err=0; grant_id=0.
2. Both requesters assert together right after reset, nl_valid after 1 cycle each -> req0 is served first, then req1. A repeat of both requests -> req0 first again, since the pointer returned to 0 after req1.
3. nl_evict high for 5 cycles while req1 WRITE is pending in IDLE -> req_evict=2'b11 for those 5 cycles; nl_request stays 0; grant occurs on the first edge after nl_evict falls.
4. TIMEOUT=8, req1 RFO, nl_valid never asserted -> nl_request high for 8 cycles; then req_valid=2'b10 with req_err=1; err_timeout stays 1 until reset.
5. req0 WRITE wdata=all 0xA5, addr 0x0000_2040; during BUSY req_addr[0]->0xFFFF_FFFF -> nl_addr stays 0x0000_2040, nl_op=2, nl_wdata=all 0xA5.
6. reset asserted in the 2nd BUSY cycle -> nl_request=0 immediately without waiting for a clock edge; after release, a req1-only request is granted with grant_id=1.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one next-level cache port between the instruction L1 (id 0)
// and the data L1 (id 1), with evict fan-out and a response timeout.
//
// state | meaning
// IDLE  | waiting for a request; no grant while nl_evict is high
// BUSY  | transaction held on the next-level port until nl_valid or timeout
// DONE  | one-cycle response pulse to the granted requester
module cache_port_arbiter #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 512,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_request,
  input  logic [3:0]            req_op,
  input  logic [2*ADDRBITS-1:0] req_addr,
  input  logic [2*DATABITS-1:0] req_wdata,
  output logic [1:0]            req_valid,
  output logic                  req_err,
  output logic [DATABITS-1:0]   req_rdata,
  output logic [1:0]            req_evict,
  output logic                  nl_request,
  output logic [1:0]            nl_op,
  output logic [ADDRBITS-1:0]   nl_addr,
  output logic [DATABITS-1:0]   nl_wdata,
  input  logic                  nl_valid,
  input  logic [DATABITS-1:0]   nl_rdata,
  input  logic                  nl_evict,
  output logic                  grant_id,
  output logic                  err_timeout
);

  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic                ptr;
  logic [CNTW-1:0]     cnt;
  logic                pend_err;
  logic [1:0]          lat_op;
  logic [ADDRBITS-1:0] lat_addr;
  logic [DATABITS-1:0] lat_wdata;
  logic [DATABITS-1:0] rdata_q;

  logic                winner;
  logic                do_grant;
  logic                do_capture;
  logic                do_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    winner     = req_request[ptr] ? ptr : ~ptr;
    case (state)
      IDLE: begin
        if (!nl_evict && (|req_request)) begin
          do_grant = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // completion wins over a timeout reached in the same cycle
        if (nl_valid) begin
          do_capture = 1'b1;
          state_nx   = DONE;
        end else if (cnt == CNT_LAST) begin
          do_timeout = 1'b1;
          state_nx   = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    nl_request = 1'b0;
    req_valid  = 2'b00;
    req_err    = 1'b0;
    if (state == BUSY) nl_request = 1'b1;
    if (state == DONE) begin
      req_valid = grant_id ? 2'b10 : 2'b01;
      req_err   = pend_err;
    end
  end

  assign req_evict = {nl_evict, nl_evict};
  assign nl_op     = lat_op;
  assign nl_addr   = lat_addr;
  assign nl_wdata  = lat_wdata;
  assign req_rdata = rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr         <= 1'b0;
      grant_id    <= 1'b0;
      cnt         <= '0;
      pend_err    <= 1'b0;
      err_timeout <= 1'b0;
      lat_op      <= 2'b00;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata_q     <= '0;
    end else begin
      if (do_grant) begin
        grant_id  <= winner;
        cnt       <= '0;
        lat_op    <= winner ? req_op[3:2] : req_op[1:0];
        lat_addr  <= winner ? req_addr[2*ADDRBITS-1:ADDRBITS] : req_addr[ADDRBITS-1:0];
        lat_wdata <= winner ? req_wdata[2*DATABITS-1:DATABITS] : req_wdata[DATABITS-1:0];
      end else if (state == BUSY && !nl_valid && cnt != CNT_LAST) begin
        cnt <= cnt + CNTW'(1);
      end
      if (do_capture) rdata_q <= nl_rdata;
      if (do_timeout) begin
        err_timeout <= 1'b1;
        pend_err    <= 1'b1;
      end
      if (state == DONE) begin
        ptr      <= ~grant_id;
        pend_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed requester/next-level scenarios,
// expected responses queued at issue time and checked by independent monitors.
module tb_cache_port_arbiter;

  localparam int AB = 32;
  localparam int DB = 512;
  localparam int TO = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_request = '0;
  logic [3:0]      req_op = '0;
  logic [2*AB-1:0] req_addr = '0;
  logic [2*DB-1:0] req_wdata = '0;
  logic [1:0]      req_valid;
  logic            req_err;
  logic [DB-1:0]   req_rdata;
  logic [1:0]      req_evict;
  logic            nl_request;
  logic [1:0]      nl_op;
  logic [AB-1:0]   nl_addr;
  logic [DB-1:0]   nl_wdata;
  logic            nl_valid = 1'b0;
  logic [DB-1:0]   nl_rdata = '0;
  logic            nl_evict = 1'b0;
  logic            grant_id;
  logic            err_timeout;

  cache_port_arbiter #(.ADDRBITS(AB), .DATABITS(DB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_request(req_request), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_valid(req_valid), .req_err(req_err), .req_rdata(req_rdata), .req_evict(req_evict),
    .nl_request(nl_request), .nl_op(nl_op), .nl_addr(nl_addr), .nl_wdata(nl_wdata),
    .nl_valid(nl_valid), .nl_rdata(nl_rdata), .nl_evict(nl_evict),
    .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    valid;
    logic          err;
    logic [DB-1:0] rdata;
  } rsp_t;

  typedef struct {
    logic [1:0]    op;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
  } nlx_t;

  rsp_t          rsp_q[$];
  nlx_t          nlx_q[$];
  logic [DB-1:0] data_q[$];
  logic [DB-1:0] model_rdata = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (req_valid != 2'b00) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", DB'(req_valid), DB'(0));
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_valid", DB'(req_valid), DB'(e.valid));
          chk("rsp_err", DB'(req_err), DB'(e.err));
          chk("rsp_rdata", req_rdata, e.rdata);
        end
      end
    end
  end

  // next-level request monitor: compares the forwarded transaction when nl_request rises
  initial begin
    logic prev;
    nlx_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (nl_request && !prev) begin
        if (nlx_q.size() == 0) begin
          chk("nl_unexpected", DB'(nl_request), DB'(0));
        end else begin
          e = nlx_q.pop_front();
          chk("nl_op", DB'(nl_op), DB'(e.op));
          chk("nl_addr", DB'(nl_addr), DB'(e.addr));
          chk("nl_wdata", nl_wdata, e.wdata);
        end
      end
      prev = nl_request;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [AB-1:0] addr,
                       input logic [DB-1:0] wdata);
    nlx_t e;
    req_op[2*id +: 2]     = op;
    req_addr[AB*id +: AB] = addr;
    req_wdata[DB*id +: DB] = wdata;
    req_request[id]       = 1'b1;
    e.op = op; e.addr = addr; e.wdata = wdata;
    nlx_q.push_back(e);
  endtask

  task automatic expect_rsp(input int id, input logic err, input logic [DB-1:0] data);
    rsp_t e;
    if (!err) begin
      model_rdata = data;
      data_q.push_back(data);
    end
    e.valid = (id == 1) ? 2'b10 : 2'b01;
    e.err   = err;
    e.rdata = model_rdata;
    rsp_q.push_back(e);
  endtask

  // requester + next-level agent; delay<0 means the next level never answers
  task automatic run(input int delay, input int budget, output int hi_cycles);
    int bc;
    int n;
    bc = 0; n = 0; hi_cycles = 0;
    while (n < budget) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) if (req_valid[i]) req_request[i] = 1'b0;
      if (nl_request) hi_cycles++;
      if (nl_valid) begin
        nl_valid = 1'b0;
        bc = 0;
      end else if (nl_request) begin
        if (bc == delay) begin
          nl_valid = 1'b1;
          nl_rdata = (data_q.size() != 0) ? data_q.pop_front() : '0;
        end
        bc++;
      end
      n++;
      if (req_request == 2'b00 && !nl_request && !nl_valid && req_valid == 2'b00) break;
    end
    chk("run_within_budget", DB'(n < budget), DB'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_request = '0;
    nl_valid = 1'b0;
    nl_evict = 1'b0;
    model_rdata = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int hi;
    logic [DB-1:0] d;

    // reset state
    do_reset();
    #1;
    chk("rst_nl_request", DB'(nl_request), DB'(0));
    chk("rst_nl_op", DB'(nl_op), DB'(0));
    chk("rst_nl_addr", DB'(nl_addr), DB'(0));
    chk("rst_nl_wdata", nl_wdata, DB'(0));
    chk("rst_req_valid", DB'(req_valid), DB'(0));
    chk("rst_req_rdata", req_rdata, DB'(0));
    chk("rst_err_timeout", DB'(err_timeout), DB'(0));
    chk("rst_grant_id", DB'(grant_id), DB'(0));

    // 1: single read from the instruction side, nl_valid 3 cycles after nl_request
    d = {16{32'hDEAD_BEEF}};
    issue(0, 2'd1, 32'h0000_1000, '0);
    expect_rsp(0, 1'b0, d);
    run(3, 40, hi);
    chk("t1_nl_busy_cycles", DB'(hi), DB'(4));
    chk("t1_grant_id", DB'(grant_id), DB'(0));

    // 2: simultaneous requests after reset, twice
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      issue(0, 2'd1, 32'h0000_0100 + 32'(rep), '0);
      issue(1, 2'd1, 32'h0000_0200 + 32'(rep), '0);
      expect_rsp(0, 1'b0, {16{32'h1111_0000 + 32'(rep)}});
      expect_rsp(1, 1'b0, {16{32'h2222_0000 + 32'(rep)}});
      run(1, 60, hi);
      chk("t2_last_grant", DB'(grant_id), DB'(1));
    end

    // 3: evict held in IDLE blocks the grant and fans out to both requesters
    nl_evict = 1'b1;
    issue(1, 2'd2, 32'h0000_5000, {16{32'h0BAD_F00D}});
    expect_rsp(1, 1'b0, {16{32'h3333_3333}});
    #1;
    chk("t3_evict_fanout", DB'(req_evict), DB'(3));
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t3_no_grant", DB'(nl_request), DB'(0));
      chk("t3_evict_hold", DB'(req_evict), DB'(3));
    end
    nl_evict = 1'b0;
    #1;
    chk("t3_evict_low", DB'(req_evict), DB'(0));
    @(negedge clock);
    chk("t3_grant_after_evict", DB'(nl_request), DB'(1));
    chk("t3_grant_id", DB'(grant_id), DB'(1));
    run(0, 40, hi);

    // 4: RFO with no next-level answer times out after TO busy cycles
    chk("t4_err_before", DB'(err_timeout), DB'(0));
    issue(1, 2'd3, 32'h0000_6000, {16{32'h0000_0077}});
    expect_rsp(1, 1'b1, '0);
    run(-1, 40, hi);
    chk("t4_busy_cycles", DB'(hi), DB'(TO));
    chk("t4_err_sticky", DB'(err_timeout), DB'(1));

    // 5: requester-side changes and evict during BUSY are ignored
    issue(0, 2'd2, 32'h0000_2040, {64{8'hA5}});
    expect_rsp(0, 1'b0, {16{32'h5555_AAAA}});
    @(negedge clock);
    req_addr[AB-1:0] = 32'hFFFF_FFFF;
    req_op[1:0]      = 2'd1;
    nl_evict         = 1'b1;
    #1;
    chk("t5_addr_held", DB'(nl_addr), DB'(32'h0000_2040));
    chk("t5_op_held", DB'(nl_op), DB'(2));
    @(negedge clock);
    nl_evict = 1'b0;
    chk("t5_still_busy", DB'(nl_request), DB'(1));
    chk("t5_wdata_held", nl_wdata, {64{8'hA5}});
    run(1, 40, hi);
    chk("t5_err_still_set", DB'(err_timeout), DB'(1));

    // 6: async reset in the second BUSY cycle, then a data-side request
    issue(0, 2'd1, 32'h0000_3000, '0);
    @(negedge clock);
    @(negedge clock);
    chk("t6_busy", DB'(nl_request), DB'(1));
    reset = 1'b1;
    req_request = '0;
    model_rdata = '0;
    #1;
    chk("t6_async_nl_request", DB'(nl_request), DB'(0));
    chk("t6_async_err", DB'(err_timeout), DB'(0));
    chk("t6_async_addr", DB'(nl_addr), DB'(0));
    @(negedge clock);
    reset = 1'b0;
    issue(1, 2'd1, 32'h0000_4000, '0);
    expect_rsp(1, 1'b0, {16{32'h6666_0006}});
    run(0, 40, hi);
    chk("t6_grant_id", DB'(grant_id), DB'(1));

    repeat (2) @(negedge clock);
    chk("rsp_queue_drained", DB'(rsp_q.size()), DB'(0));
    chk("nl_queue_drained", DB'(nlx_q.size()), DB'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
